// File: rtl/rd_burst_arb_fsm.sv
// Round-robin arbiter and multi-beat read-burst controller with wait-state retry.
// Every output is registered and is computed from the next state, so it changes on the same edge as the state.
module rd_burst_arb_fsm #(
  parameter int N_CH      = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH*LEN_W-1:0] len,
  input  logic                  ws,
  output logic [N_CH-1:0]       gnt,
  output logic                  rd,
  output logic                  ds,
  output logic                  err,
  output logic [LEN_W-1:0]      beat
);

  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    DLY  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [RETRY_W-1:0]   retry, retry_nxt;
  logic [LEN_W-1:0]     remaining, remaining_nxt;
  logic [LEN_W-1:0]     beat_nxt;
  logic [N_CH-1:0]      gnt_nxt;
  logic                 rd_nxt, ds_nxt, err_nxt;
  logic                 found;
  logic [PTR_W-1:0]     pick, cand;

  // The search starts just above the last grant and wraps, so the last winner ranks lowest.
  always_comb begin : arb
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_CH);
      if (!found && start[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin : fsm
    state_nxt     = state;
    ptr_nxt       = ptr;
    retry_nxt     = retry;
    remaining_nxt = remaining;
    beat_nxt      = beat;
    gnt_nxt       = gnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = READ;
          ptr_nxt       = pick;
          remaining_nxt = len[int'(pick)*LEN_W +: LEN_W];
          beat_nxt      = '0;
          retry_nxt     = '0;
          gnt_nxt       = N_CH'(1) << pick;
        end
      end
      READ: state_nxt = DLY;
      DLY: begin
        if (ws) begin
          if (retry == RETRY_W'(MAX_RETRY)) begin
            state_nxt = ERR;
          end else begin
            retry_nxt = retry + RETRY_W'(1);
            state_nxt = READ;
          end
        end else begin
          retry_nxt = '0;
          if (remaining == '0) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = remaining - LEN_W'(1);
            beat_nxt      = beat + LEN_W'(1);
            state_nxt     = READ;
          end
        end
      end
      DONE, ERR: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
`ifndef SYNTHESIS
        state_nxt = state_t'('x);
        gnt_nxt   = 'x;
        beat_nxt  = 'x;
`else
        state_nxt = IDLE;
        gnt_nxt   = '0;
        beat_nxt  = '0;
`endif
      end
    endcase
    rd_nxt  = (state_nxt == READ) || (state_nxt == DLY);
    ds_nxt  = (state_nxt == DONE);
    err_nxt = (state_nxt == ERR);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PTR_W'(N_CH - 1);
      retry     <= '0;
      remaining <= '0;
      beat      <= '0;
      gnt       <= '0;
      rd        <= 1'b0;
      ds        <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      retry     <= retry_nxt;
      remaining <= remaining_nxt;
      beat      <= beat_nxt;
      gnt       <= gnt_nxt;
      rd        <= rd_nxt;
      ds        <= ds_nxt;
      err       <= err_nxt;
    end
  end

endmodule
